// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX blocks: sequencer state codes, default
// sync header bytes and the checksum accumulate step.
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_STAGE = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h55;

  function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/tx_frame_sequencer_if.sv
// Sequencer-side view of the TX RAM read port and the byte-wide UART transmitter.
interface tx_frame_sequencer_if #(
  parameter int AW = 8
);
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;
  logic          uart_start;
  logic [7:0]    uart_data;
  logic          uart_busy;
  logic          uart_done;

  modport master (
    output ram_re, ram_addr, uart_start, uart_data,
    input  ram_rdata, uart_busy, uart_done
  );

  modport slave (
    input  ram_re, ram_addr, uart_start, uart_data,
    output ram_rdata, uart_busy, uart_done
  );
endinterface

// File: rtl/tx_frame_sequencer.sv
// Sequences one framed packet (sync, sync, frame id, RAM payload, checksum)
// onto the UART transmitter per frame tick; counts ticks dropped while busy.
module tx_frame_sequencer
  import uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 176,
  parameter logic [7:0]  SYNC0 = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1 = SYNC1_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic                         pause,
  output logic                         busy,
  output logic                         frame_sent,
  output logic [7:0]                   overrun_cnt,
  tx_frame_sequencer_if.master         bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(DEPTH + 4);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH + 3);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    cksum_q, cksum_d;
  logic [7:0]    frame_id_q, frame_id_d;
  logic          ram_re_q, ram_re_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          uart_start_q, uart_start_d;
  logic [7:0]    uart_data_q, uart_data_d;
  logic          busy_q, busy_d;
  logic          frame_sent_q, frame_sent_d;
  logic [7:0]    overrun_q, overrun_d;
  logic [7:0]    stage_byte_s;
  logic          can_start_s;
  logic          cur_payload_s;
  logic          next_payload_s;

  assign can_start_s    = !pause && !bus.uart_busy;
  assign cur_payload_s  = (idx_q >= IW'(3)) && (idx_q != LAST_IDX);
  assign next_payload_s = (idx_d >= IW'(3)) && (idx_d != LAST_IDX);

  always_comb begin
    if (idx_q == IW'(0)) begin
      stage_byte_s = SYNC0;
    end else if (idx_q == IW'(1)) begin
      stage_byte_s = SYNC1;
    end else if (idx_q == IW'(2)) begin
      stage_byte_s = frame_id_q;
    end else if (idx_q == LAST_IDX) begin
      stage_byte_s = cksum_q;
    end else begin
      stage_byte_s = bus.ram_rdata;
    end
  end

  // STAGE also evaluates the start condition so the first start lands three cycles after the tick
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cksum_d      = cksum_q;
    frame_id_d   = frame_id_q;
    ram_re_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    uart_start_d = 1'b0;
    uart_data_d  = uart_data_q;
    busy_d       = busy_q;
    frame_sent_d = 1'b0;

    if (frame_tick && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          cksum_d = 8'h00;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_STAGE;
      end
      ST_STAGE: begin
        uart_data_d = stage_byte_s;
        if (idx_q == IW'(2)) begin
          cksum_d = cksum_add(cksum_q, frame_id_q);
        end else if (cur_payload_s) begin
          cksum_d = cksum_add(cksum_q, bus.ram_rdata);
        end else begin
          cksum_d = cksum_q;
        end
        if (can_start_s) begin
          uart_start_d = 1'b1;
          state_d      = ST_WAIT;
        end else begin
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (can_start_s) begin
          uart_start_d = 1'b1;
          state_d      = ST_WAIT;
        end else begin
          state_d      = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (bus.uart_done) begin
          if (idx_q == LAST_IDX) begin
            state_d      = ST_IDLE;
            frame_sent_d = 1'b1;
            busy_d       = 1'b0;
            frame_id_d   = frame_id_q + 8'd1;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Read is registered on entry to LOAD so ram_re is high during LOAD itself
    if ((state_d == ST_LOAD) && (state_q != ST_LOAD) && next_payload_s) begin
      ram_re_d   = 1'b1;
      ram_addr_d = AW'(idx_d - IW'(3));
    end else begin
      ram_re_d   = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cksum_q      <= 8'h00;
      frame_id_q   <= 8'h00;
      ram_re_q     <= 1'b0;
      ram_addr_q   <= '0;
      uart_start_q <= 1'b0;
      uart_data_q  <= 8'h00;
      busy_q       <= 1'b0;
      frame_sent_q <= 1'b0;
      overrun_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cksum_q      <= cksum_d;
      frame_id_q   <= frame_id_d;
      ram_re_q     <= ram_re_d;
      ram_addr_q   <= ram_addr_d;
      uart_start_q <= uart_start_d;
      uart_data_q  <= uart_data_d;
      busy_q       <= busy_d;
      frame_sent_q <= frame_sent_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.ram_re     = ram_re_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.uart_start = uart_start_q;
  assign bus.uart_data  = uart_data_q;
  assign busy           = busy_q;
  assign frame_sent     = frame_sent_q;
  assign overrun_cnt    = overrun_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer with DEPTH=4, a one-cycle-latency
// RAM model and a 10-cycle-per-byte transmitter model.
module tb_tx_frame_sequencer;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       pause = 1'b0;
  logic       busy;
  logic       frame_sent;
  logic [7:0] overrun_cnt;

  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         fs_cnt = 0;
  int         tx_cnt = 0;
  logic       prev_done = 1'b0;

  tx_frame_sequencer_if #(.AW(2)) bus ();

  tx_frame_sequencer #(.DEPTH(DEPTH), .SYNC0(8'hAA), .SYNC1(8'h55)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .pause       (pause),
    .busy        (busy),
    .frame_sent  (frame_sent),
    .overrun_cnt (overrun_cnt),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // RAM: data valid the cycle after the read enable
  always @(posedge clk) begin
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Transmitter: busy from the cycle after start, done pulse 10 cycles later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt <= 0;
      bus.uart_busy <= 1'b0;
      bus.uart_done <= 1'b0;
    end else begin
      bus.uart_done <= 1'b0;
      if (tx_cnt != 0) begin
        tx_cnt <= tx_cnt - 1;
        if (tx_cnt == 1) begin
          bus.uart_done <= 1'b1;
          bus.uart_busy <= 1'b0;
        end
      end else if (bus.uart_start) begin
        tx_cnt <= 10;
        bus.uart_busy <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each start is popped against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.uart_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", {24'h0, bus.uart_data}, 32'hFFFF_FFFF);
        end else begin
          chk("byte", {24'h0, bus.uart_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (frame_sent) begin
        fs_cnt++;
        chk("fs_busy_low", {31'h0, busy}, 32'h0);
        chk("fs_after_done", {31'h0, prev_done}, 32'h1);
      end
      prev_done = bus.uart_done;
    end
  end

  task automatic push_pkt(input logic [7:0] id, input logic [7:0] ck);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(id);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    exp_q.push_back(ck);
  endtask

  // Called at a negedge: the tick occupies the following cycle T
  task automatic start_frame(input bit chk_timing);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if (chk_timing) begin
      chk("busy_T+1", {31'h0, busy}, 32'h1);
      @(negedge clk);
      chk("start_T+2", {31'h0, bus.uart_start}, 32'h0);
      @(negedge clk);
      chk("start_T+3", {31'h0, bus.uart_start}, 32'h1);
    end
  endtask

  task automatic wait_frame();
    int low = 0;
    bit got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_sent) begin
        got = 1'b1;
        break;
      end
      if (!busy) low++;
    end
    chk("frame_done", {31'h0, got}, 32'h1);
    chk("busy_in_pkt", low, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ram_re", {31'h0, bus.ram_re}, 32'h0);
    chk("rst_ram_addr", {30'h0, bus.ram_addr}, 32'h0);
    chk("rst_uart_start", {31'h0, bus.uart_start}, 32'h0);
    chk("rst_uart_data", {24'h0, bus.uart_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_frame_sent", {31'h0, frame_sent}, 32'h0);
    chk("rst_overrun", {24'h0, overrun_cnt}, 32'h0);
  endtask

  initial begin
    int seen;
    int viol;
    bit hit;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame: AA 55 00 01 02 03 04 0A
    push_pkt(8'h00, 8'h0A);
    start_frame(1'b1);
    wait_frame();
    repeat (5) @(negedge clk);
    chk("fs_once", fs_cnt, 1);

    // Back-to-back frames, second tick in the cycle frame_sent is high
    push_pkt(8'h01, 8'h0B);
    start_frame(1'b1);
    wait_frame();
    push_pkt(8'h02, 8'h0C);
    start_frame(1'b1);
    wait_frame();

    // Tick mid-packet and tick coincident with the final done are both dropped
    push_pkt(8'h03, 8'h0D);
    start_frame(1'b1);
    repeat (30) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.uart_done && exp_q.size() == 0) begin
        hit = 1'b1;
        break;
      end
    end
    chk("final_done_seen", {31'h0, hit}, 32'h1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("ovr_fs_D+1", {31'h0, frame_sent}, 32'h1);
    chk("ovr_cnt_2", {24'h0, overrun_cnt}, 32'h2);
    @(negedge clk);
    chk("ovr_not_accepted", {31'h0, busy}, 32'h0);
    repeat (20) @(negedge clk);

    // Pause from the 2nd byte's done (just before the 3rd start) for 50 cycles
    push_pkt(8'h04, 8'h0E);
    start_frame(1'b1);
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.uart_done) seen++;
      if (seen == 2) break;
    end
    chk("pause_2nd_done", seen, 2);
    pause = 1'b1;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.uart_start) viol++;
    end
    chk("pause_no_start", viol, 0);
    pause = 1'b0;
    @(negedge clk);
    chk("pause_release_start", {31'h0, bus.uart_start}, 32'h1);
    wait_frame();

    // Reset during a payload byte
    push_pkt(8'h05, 8'h0F);
    start_frame(1'b1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() <= 4) break;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", {31'h0, busy}, 32'h0);
    push_pkt(8'h00, 8'h0A);
    start_frame(1'b1);
    wait_frame();

    // 300 dropped ticks while the packet is held by pause
    push_pkt(8'h01, 8'h0B);
    pause = 1'b1;
    frame_tick = 1'b1;
    repeat (255) @(negedge clk);
    chk("ovr_254", {24'h0, overrun_cnt}, 32'd254);
    repeat (46) @(negedge clk);
    frame_tick = 1'b0;
    chk("ovr_sat_255", {24'h0, overrun_cnt}, 32'd255);
    repeat (3) @(negedge clk);
    chk("ovr_hold_255", {24'h0, overrun_cnt}, 32'd255);
    pause = 1'b0;
    wait_frame();

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("fs_total", fs_cnt, 7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Controller for the pixel-stream UART transmit path. On each frame tick it sequences one framed packet onto the byte-wide UART transmitter: two sync bytes, a frame index, every byte of the packed-pixel TX RAM in address order, and an 8-bit checksum. It owns the RAM read port and the transmitter start strobe, honours a host pause input between bytes, and counts frame ticks that arrive while a packet is still in flight.

## Interface
- DEPTH, 176: payload bytes per frame (TX RAM depth), ≥1
- SYNC0, 8'hAA: first header byte
- SYNC1, 8'h55: second header byte
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse: RAM holds a complete frame
- ram_re  out  1  RAM read enable, one-cycle pulse
- ram_addr  out  $clog2(DEPTH)  RAM read address, valid with ram_re
- ram_rdata  in  8  RAM read data, valid the cycle after ram_re
- uart_start  out  1  transmitter start, one-cycle pulse
- uart_data  out  8  byte to send; stable from uart_start until uart_done
- uart_busy  in  1  transmitter busy level
- uart_done  in  1  transmitter byte-complete pulse
- pause  in  1  host flow control; high blocks the next start
- busy  out  1  packet in progress
- frame_sent  out  1  one-cycle pulse: last byte of packet completed
- overrun_cnt  out  8  dropped frame ticks, saturating

## Operation
- Byte sequence per packet: SYNC0, SYNC1, frame_id, payload[0..DEPTH-1], cksum; DEPTH+4 bytes total.
- cksum: 8-bit sum modulo 256 of frame_id and all payload bytes. Sync bytes are excluded. The accumulator clears at packet start.
- frame_id: internal 8-bit counter, 0 after reset. It increments when frame_sent fires and wraps from 255 to 0.
- States:
  - IDLE: on frame_tick, go to LOAD; byte index = 0, busy = 1.
  - LOAD: select the byte source. For payload bytes, pulse ram_re with ram_addr = index−3. Go to STAGE.
  - STAGE: latch the selected byte (ram_rdata for payload) into uart_data and update the checksum. Go to SEND.
  - SEND: if pause = 0 and uart_busy = 0, pulse uart_start and go to WAIT. Otherwise hold.
  - WAIT: on uart_done, if this was the last byte, go to IDLE and pulse frame_sent. Otherwise index++ and go to LOAD.
- pause only gates the SEND→start decision. A byte already started is never aborted.
- uart_done outside WAIT is ignored.
- frame_tick outside IDLE drops the frame and increments overrun_cnt, which saturates at 255. This includes frame_tick coincident with the final uart_done.
- Reset mid-packet: return to IDLE immediately and clear frame_id, overrun_cnt and the checksum. No further uart_start is issued.

## Timing
- Reset values: ram_re 0, ram_addr 0, uart_start 0, uart_data 0, busy 0, frame_sent 0, overrun_cnt 0.
- All outputs are registered.
- frame_tick in cycle T: busy = 1 from T+1, and the first uart_start in T+3 if pause = 0 and uart_busy = 0.
- uart_done in cycle D for a non-final byte: next uart_start in D+3 at the earliest.
- Payload ram_re is asserted in LOAD; the data is captured in STAGE one cycle later. There is exactly one RAM read per payload byte.
- Final uart_done in cycle D: frame_sent = 1 in D+1, busy = 0 in D+1, and a frame_tick in D+1 is accepted.
- Minimum packet time: (DEPTH+4) × (3 + transmitter byte time) cycles.

## Structure
- Shared package uart_tx_pkg: the state enum (IDLE, LOAD, STAGE, SEND, WAIT) and the SYNC0/SYNC1 default constants. Other UART TX blocks reuse these.
- Single module with no sub-module. The checksum accumulator and index counter are inline registers.
- Index width is $clog2(DEPTH+4).

## Test plan
- DEPTH=4, RAM = 01 02 03 04, one frame_tick, transmitter model with 10-cycle byte time: bytes AA 55 00 01 02 03 04 0A; frame_sent once; then frame_id = 1.
- Two back-to-back frames: the second packet carries frame_id 01 and cksum 0B; busy is high throughout each packet.
- frame_tick injected mid-packet, and again in the same cycle as the final uart_done: both dropped, overrun_cnt = 2, packet contents unchanged.
- pause held high for 50 cycles starting just before the 3rd byte's start: no uart_start while paused; the 3rd byte's uart_start follows 1 cycle after pause falls; the byte order is intact.
- Reset asserted during a payload byte: all outputs return to their reset values at once. A new frame_tick then sends a packet with frame_id 00.
- overrun_cnt driven with 300 dropped ticks: saturates at 255.
